// File: rtl/pll_seq_pkg.sv
// Shared definitions for the pixel-clock PLL reset sequencer.
// The state encoding is visible on state_o. The CSR block decodes it with this
// same package, so the values must stay fixed.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET_PLL = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET_PLL = ST_RESET_PLL,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_STABLE    = ST_STABLE,
    S_RUN       = ST_RUN,
    S_FAULT     = ST_FAULT
  } state_e;

  // The PLL is held in reset while pulsing and while faulted.
  function automatic logic pll_held(input logic [STATE_W-1:0] st);
    return (st == ST_RESET_PLL) || (st == ST_FAULT);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer with async active-low clear.
//   i_clk   destination clock
//   i_rst_n async clear, active-low (both stages clear to 0)
//   i_d     asynchronous input bus (each bit must be independent)
//   o_q     synchronized output, 2 cycles of latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences the pixel PLL reset, qualifies lock and
// gates the video-domain reset. It watches for lock loss and retries a bounded
// number of times before it latches FAULT.
//   refclk        free-running reference clock
//   rst_n         async active-low reset, released through a 2-flop synchronizer
//   pll_locked    PLL lock flag, asynchronous to refclk
//   restart       single-cycle re-sequence request (refclk domain)
//   pll_rst       PLL reset, active-high
//   dom_rst_n     video-domain reset, active-low
//   ready / fault high only in RUN / FAULT
//   state_o       current state encoding
//   lock_loss_cnt saturating count of lock losses seen in RUN
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               dom_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state_o,
  output logic [7:0]         lock_loss_cnt
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic               w_rst_n;
  logic               w_lk_s;
  logic [STATE_W-1:0] r_state, w_nstate;
  logic [CNT_W-1:0]   r_cnt;
  logic [RW-1:0]      r_retry, w_retry_nxt, w_retry_inc;
  logic [7:0]         r_llc;
  logic               r_pll_rst, r_dom_rst_n, r_ready, r_fault;
  logic               w_clr;

  // Reset asserts asynchronously and releases on a refclk edge.
  sync_2ff #(.W(1)) u_rst_sync (
    .i_clk(refclk), .i_rst_n(rst_n), .i_d(1'b1), .o_q(w_rst_n)
  );

  sync_2ff #(.W(1)) u_lock_sync (
    .i_clk(refclk), .i_rst_n(w_rst_n), .i_d(pll_locked), .o_q(w_lk_s)
  );

  assign w_retry_inc = r_retry + RW'(1);

  always_comb begin
    w_nstate    = r_state;
    w_retry_nxt = r_retry;
    if (restart) begin
      w_nstate    = ST_RESET_PLL;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_RESET_PLL: if (r_cnt == RST_TERM) w_nstate = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          // Lock takes priority over a timeout that lands in the same cycle.
          if (w_lk_s) begin
            w_nstate = ST_STABLE;
          end else if (r_cnt == TO_TERM) begin
            w_retry_nxt = w_retry_inc;
            w_nstate    = (w_retry_inc == RW'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
          end
        end
        ST_STABLE: begin
          if (!w_lk_s) begin
            w_nstate = ST_WAIT_LOCK;
          end else if (r_cnt == STB_TERM) begin
            w_nstate    = ST_RUN;
            w_retry_nxt = '0;
          end
        end
        ST_RUN:   if (!w_lk_s) w_nstate = ST_RESET_PLL;
        ST_FAULT: w_nstate = ST_FAULT;
        default:  w_nstate = ST_RESET_PLL;
      endcase
    end
  end

  // The counter clears on every state entry. restart also clears it when the
  // FSM is already in RESET_PLL.
  assign w_clr = restart || (w_nstate != r_state);

  // Outputs are registered from the next state, so they change on the same
  // edge as state_o. A lock drop therefore reaches dom_rst_n in 3 edges.
  always_ff @(posedge refclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_llc       <= '0;
      r_pll_rst   <= 1'b1;
      r_dom_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_retry <= w_retry_nxt;
      if (w_clr)          r_cnt <= '0;
      else if (~&r_cnt)   r_cnt <= r_cnt + 1'b1;
      // Lock loss is counted even when restart wins the same cycle.
      if (r_state == ST_RUN && !w_lk_s && r_llc != 8'hFF) r_llc <= r_llc + 8'd1;
      r_pll_rst   <= pll_held(w_nstate);
      r_dom_rst_n <= (w_nstate == ST_RUN);
      r_ready     <= (w_nstate == ST_RUN);
      r_fault     <= (w_nstate == ST_FAULT);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign dom_rst_n     = r_dom_rst_n;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign state_o       = r_state;
  assign lock_loss_cnt = r_llc;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
// Expected values are queued when stimulus is applied and popped at the
// matching sample point. Inputs change and outputs are sampled on the falling edge.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       dom_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .ready(ready), .fault(fault),
    .state_o(state_o), .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic ex(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, e);
    end
  endtask

  // Bounded wait for RUN; running out of cycles fails the check.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    ex(1); chk(tag, {31'd0, ready});
  endtask

  // One-cycle lock glitch in RUN, then wait for the block to return to RUN.
  task automatic lose_lock();
    pll_locked = 1'b0; step(1); pll_locked = 1'b1; step(2);
    wait_ready("t5_loss_rerun");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed hang expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    step(3);
    ex(1); ex(0); ex(0); ex(0); ex(0); ex(0);
    chk("rst_pll_rst", pll_rst); chk("rst_dom_rst_n", dom_rst_n);
    chk("rst_ready", ready); chk("rst_fault", fault);
    chk("rst_state", state_o); chk("rst_llc", lock_loss_cnt);

    // 1: bring-up. Two edges of reset sync plus a 4-cycle pulse.
    rst_n = 1'b1;
    ex(1); step(5); chk("t1_pll_rst_held", pll_rst);
    ex(0); ex(1); step(1); chk("t1_pll_rst_fall", pll_rst); chk("t1_state_wait", state_o);
    step(10); pll_locked = 1'b1;
    ex(0); ex(2); step(10); chk("t1_ready_early", ready); chk("t1_state_stable", state_o);
    ex(1); ex(1); ex(3); step(1);
    chk("t1_ready", ready); chk("t1_dom_rst_n", dom_rst_n); chk("t1_state_run", state_o);

    // 2: glitchy lock
    pll_locked = 1'b0; restart = 1'b1;
    ex(1); ex(0); step(1); chk("t2_restart_pll_rst", pll_rst); chk("t2_restart_state", state_o);
    restart = 1'b0;
    ex(1); step(3); chk("t2_pulse_hold", pll_rst);
    ex(0); ex(1); step(1); chk("t2_pulse_end", pll_rst); chk("t2_state_wait", state_o);
    pll_locked = 1'b1; step(5); pll_locked = 1'b0; step(1); pll_locked = 1'b1;
    ex(1); step(2); chk("t2_back_to_wait", state_o);
    ex(0); chk("t2_retry", 32'(dut.r_retry));
    ex(0); ex(2); step(8); chk("t2_ready_early", ready); chk("t2_state_stable", state_o);
    ex(1); step(1); chk("t2_ready", ready);

    // 3: lock loss in RUN
    pll_locked = 1'b0;
    ex(1); step(2); chk("t3_dom_still_high", dom_rst_n);
    ex(0); ex(1); ex(1); step(1);
    chk("t3_dom_low_edge3", dom_rst_n); chk("t3_pll_rst", pll_rst); chk("t3_llc", lock_loss_cnt);
    ex(1); step(3); chk("t3_pulse_hold", pll_rst);
    ex(0); step(1); chk("t3_pulse_end", pll_rst);
    pll_locked = 1'b1;
    ex(0); step(10); chk("t3_ready_early", ready);
    ex(1); step(1); chk("t3_ready", ready);

    // 4: no lock leads to FAULT after two timeouts
    pll_locked = 1'b0; restart = 1'b1; step(1); restart = 1'b0;
    ex(1); ex(0); step(23); chk("t4_wait1_state", state_o); chk("t4_wait1_pll_rst", pll_rst);
    ex(0); ex(1); step(1); chk("t4_retry_state", state_o); chk("t4_retry_pll_rst", pll_rst);
    ex(1); step(3); chk("t4_pulse_hold", pll_rst);
    ex(0); ex(1); step(1); chk("t4_pulse_end", pll_rst); chk("t4_wait2_state", state_o);
    ex(0); ex(1); step(19); chk("t4_fault_early", fault); chk("t4_wait2_last", state_o);
    ex(1); ex(4); ex(1); ex(0); ex(0); step(1);
    chk("t4_fault", fault); chk("t4_fault_state", state_o); chk("t4_fault_pll_rst", pll_rst);
    chk("t4_fault_dom", dom_rst_n); chk("t4_fault_ready", ready);
    ex(4); step(5); chk("t4_fault_sticky", state_o);
    restart = 1'b1;
    ex(0); ex(0); ex(1); step(1);
    chk("t4_restart_fault", fault); chk("t4_restart_state", state_o); chk("t4_restart_pll_rst", pll_rst);
    restart = 1'b0; pll_locked = 1'b1;
    ex(1); step(3); chk("t4_fresh_hold", pll_rst);
    ex(0); step(1); chk("t4_fresh_end", pll_rst);
    wait_ready("t4_rerun");

    // 5: restart and lock drop land in the same cycle in RUN
    pll_locked = 1'b0; step(2); restart = 1'b1;
    ex(0); ex(2); ex(0); ex(1); step(1);
    chk("t5_prio_state", state_o); chk("t5_prio_llc", lock_loss_cnt);
    chk("t5_prio_retry", 32'(dut.r_retry)); chk("t5_prio_pll_rst", pll_rst);
    restart = 1'b0; pll_locked = 1'b1;
    ex(1); step(3); chk("t5_pulse_hold", pll_rst);
    ex(0); ex(1); step(1); chk("t5_pulse_end", pll_rst); chk("t5_state_wait", state_o);
    wait_ready("t5_prio_rerun");
    for (int i = 0; i < 253; i++) lose_lock();
    ex(255); chk("t5_llc_255", lock_loss_cnt);
    for (int i = 0; i < 5; i++) lose_lock();
    ex(255); chk("t5_llc_sat", lock_loss_cnt);

    // 6: async reset during STABLE
    pll_locked = 1'b0; step(1); pll_locked = 1'b1;
    ex(2); step(8); chk("t6_in_stable", state_o);
    #2 rst_n = 1'b0;
    #1;
    ex(1); ex(0); ex(0); ex(0); ex(0); ex(0);
    chk("t6_pll_rst", pll_rst); chk("t6_dom_rst_n", dom_rst_n); chk("t6_ready", ready);
    chk("t6_fault", fault); chk("t6_state", state_o); chk("t6_llc", lock_loss_cnt);
    step(1); rst_n = 1'b1;
    ex(1); step(5); chk("t6_pll_rst_held", pll_rst);
    ex(0); step(1); chk("t6_pll_rst_fall", pll_rst);
    ex(0); step(8); chk("t6_ready_early", ready);
    ex(1); step(1); chk("t6_ready", ready);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
